cam_capture_axis: RTL and testbench

Camera capture front end on the sensor pixel-clock domain. Samples an OV7670-style parallel bus (VSYNC, HREF, 8-bit data), assembles two bytes per RGB565 pixel, tags each pixel with start-of-frame and end-of-line, and drives the compact write-side stream of the downstream async AXIS FIFO. The sensor cannot be stalled, so beats refused by the FIFO are dropped and flagged.

---
 rtl/cam_capture_axis.sv | 141 ++++++++++++++
 tb/tb_cam_capture_axis.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture_axis.sv
// OV7670-style parallel camera capture: pairs bytes into RGB565 pixels, tags SOF/EOL,
// and writes them into an async AXIS FIFO. The sensor cannot be stalled, so refused beats are dropped.
module cam_capture_axis #(
  parameter int TDATA_WIDTH = 32,
  parameter int TUSER_WIDTH = 1,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480
) (
  input  logic                               i_wclk,
  input  logic                               i_rrstn,
  input  logic                               i_vsync,
  input  logic                               i_href,
  input  logic [7:0]                         i_data,
  input  logic                               i_en,
  input  logic                               i_clr_err,
  input  logic                               i_sready,
  output logic                               o_wr_valid,
  output logic [TDATA_WIDTH+TUSER_WIDTH:0]   o_wr_data,
  output logic                               o_frame_done,
  output logic [15:0]                        o_frame_cnt,
  output logic                               o_overflow,
  output logic                               o_line_err
);

  localparam logic [11:0] H_MAX  = 12'(H_ACTIVE);
  localparam logic [11:0] H_LAST = 12'(H_ACTIVE - 1);
  localparam logic [11:0] V_MAX  = 12'(V_ACTIVE);

  typedef enum logic [1:0] {S_WAIT_VS, S_VSYNC, S_ACTIVE} state_t;
  state_t state, state_nxt;

  logic       v_q, h_q, v_qq, h_qq;
  logic [7:0] d_q, hi_byte;
  logic       phase;
  logic [11:0] x, y;

  logic v_fall, h_rise, h_fall, capturing, byte_lo, pix_done, hi_latch;
  logic in_range, line_end, last_line, abort, enter_active;
  logic set_ovf, set_le;
  logic [TDATA_WIDTH-1:0] tdata;
  logic [TUSER_WIDTH-1:0] tuser;
  logic                   tlast;

  always_comb begin
    v_fall       = v_qq & ~v_q;
    h_rise       = h_q & ~h_qq;
    h_fall       = h_qq & ~h_q;
    capturing    = (state == S_ACTIVE) && !v_q;
    // An HREF rising edge forces phase 0 regardless of the stored phase bit.
    byte_lo      = h_q && !h_rise && phase;
    hi_latch     = h_q && !byte_lo;
    pix_done     = capturing && byte_lo;
    in_range     = x < H_MAX;
    line_end     = capturing && h_fall;
    last_line    = line_end && (x != '0) && ((y + 12'd1) == V_MAX);
    abort        = (state == S_ACTIVE) && v_q && (y < V_MAX);
    enter_active = (state == S_VSYNC) && v_fall && i_en;
    set_ovf      = pix_done && in_range && !i_sready;
    set_le       = (pix_done && !in_range) || (line_end && (x != H_MAX)) || abort;
    tdata        = '0;
    tdata[15:0]  = {hi_byte, d_q};
    tuser        = '0;
    tuser[0]     = (x == '0) && (y == '0);
    tlast        = (x == H_LAST);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT_VS: if (v_q) state_nxt = S_VSYNC;
      S_VSYNC:   if (v_fall) state_nxt = i_en ? S_ACTIVE : S_WAIT_VS;
      S_ACTIVE: begin
        if (v_q)            state_nxt = S_VSYNC;
        else if (last_line) state_nxt = S_WAIT_VS;
      end
      default:   state_nxt = S_WAIT_VS;
    endcase
  end

  always_ff @(posedge i_wclk or negedge i_rrstn) begin
    if (!i_rrstn) state <= S_WAIT_VS;
    else          state <= state_nxt;
  end

  always_ff @(posedge i_wclk or negedge i_rrstn) begin
    if (!i_rrstn) begin
      v_q          <= 1'b0;
      h_q          <= 1'b0;
      v_qq         <= 1'b0;
      h_qq         <= 1'b0;
      d_q          <= '0;
      hi_byte      <= '0;
      phase        <= 1'b0;
      x            <= '0;
      y            <= '0;
      o_wr_valid   <= 1'b0;
      o_wr_data    <= '0;
      o_frame_done <= 1'b0;
      o_frame_cnt  <= '0;
      o_overflow   <= 1'b0;
      o_line_err   <= 1'b0;
    end else begin
      v_q          <= i_vsync;
      h_q          <= i_href;
      d_q          <= i_data;
      v_qq         <= v_q;
      h_qq         <= h_q;
      o_wr_valid   <= 1'b0;
      o_frame_done <= 1'b0;
      phase        <= hi_latch && !enter_active;
      if (hi_latch) hi_byte <= d_q;

      if (enter_active) begin
        x <= '0;
        y <= '0;
      end else if (pix_done && in_range) begin
        x <= x + 12'd1;
        if (i_sready) begin
          o_wr_valid <= 1'b1;
          o_wr_data  <= {tdata, tuser, tlast};
        end
      end else if (line_end && (x != '0)) begin
        x <= '0;
        y <= y + 12'd1;
      end

      if (last_line) begin
        o_frame_done <= 1'b1;
        o_frame_cnt  <= o_frame_cnt + 16'd1;
      end

      if (i_clr_err) begin
        o_overflow <= 1'b0;
        o_line_err <= 1'b0;
      end
      if (set_ovf) o_overflow <= 1'b1;
      if (set_le)  o_line_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cam_capture_axis.sv
// Bench for cam_capture_axis (H_ACTIVE=4, V_ACTIVE=2): directed frame table plus random frames
// compared against a per-frame reference model of the capture rules.
`timescale 1ns/1ps
module tb_cam_capture_axis;

  localparam int H = 4;
  localparam int V = 2;

  logic        i_wclk = 1'b0;
  logic        i_rrstn, i_vsync, i_href, i_en, i_clr_err, i_sready;
  logic [7:0]  i_data;
  logic        o_wr_valid, o_frame_done, o_overflow, o_line_err;
  logic [33:0] o_wr_data;
  logic [15:0] o_frame_cnt;

  cam_capture_axis #(.TDATA_WIDTH(32), .TUSER_WIDTH(1), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .i_wclk(i_wclk), .i_rrstn(i_rrstn), .i_vsync(i_vsync), .i_href(i_href), .i_data(i_data),
    .i_en(i_en), .i_clr_err(i_clr_err), .i_sready(i_sready), .o_wr_valid(o_wr_valid),
    .o_wr_data(o_wr_data), .o_frame_done(o_frame_done), .o_frame_cnt(o_frame_cnt),
    .o_overflow(o_overflow), .o_line_err(o_line_err)
  );

  always #5 i_wclk = ~i_wclk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Beat collector
  logic [33:0] got_q[$];
  int          done_cnt = 0;
  logic        prev_valid = 1'b0;

  always @(posedge i_wclk) begin
    #1;
    if (o_wr_valid) begin
      got_q.push_back(o_wr_data);
      check("beat_single_cycle", {63'd0, prev_valid}, 64'd0);
    end
    if (o_frame_done) done_cnt++;
    prev_valid = o_wr_valid;
  end

  // Current frame description
  bit          en_a, odd_a;
  int          nl_a;
  int          len_a[4];
  logic [15:0] pix_a[4][8];
  bit          rdy_a[4][8];

  // Model outputs
  logic [33:0] exp_q[$];
  int          exp_done;
  bit          exp_le, exp_ovf;
  logic [15:0] exp_cnt = 16'd0;

  task automatic setup_frame(input bit en, input int nl, input int l0, input int l1, input int l2,
                             input bit odd, input int drop, input bit rnd);
    logic [7:0] bb;
    int g;
    bb = 8'h12;
    g = 0;
    en_a = en; nl_a = nl; odd_a = odd;
    len_a[0] = l0; len_a[1] = l1; len_a[2] = l2; len_a[3] = 0;
    for (int l = 0; l < 4; l++)
      for (int p = 0; p < 8; p++) begin
        if (rnd) begin
          pix_a[l][p] = 16'($urandom);
          rdy_a[l][p] = ($urandom_range(0, 7) != 0);
        end else begin
          pix_a[l][p][15:8] = bb; bb = bb + 8'h22;
          pix_a[l][p][7:0]  = bb; bb = bb + 8'h22;
          rdy_a[l][p] = (g != drop);
        end
        if (l < nl && p < len_a[l]) g++;
      end
  endtask

  // Entered with VSYNC high; leaves VSYNC high again after the frame.
  task automatic drive_frame();
    bit nxt;
    @(negedge i_wclk); i_en = en_a; i_vsync = 1'b0;
    repeat (4) @(negedge i_wclk);
    for (int l = 0; l < nl_a; l++) begin
      nxt = 1'b1;
      for (int p = 0; p < len_a[l]; p++)
        for (int b = 0; b < 2; b++) begin
          @(negedge i_wclk);
          i_href = 1'b1;
          i_data = (b == 1) ? pix_a[l][p][7:0] : pix_a[l][p][15:8];
          i_sready = nxt;
          nxt = (b == 1) ? rdy_a[l][p] : 1'b1;
        end
      if (odd_a) begin
        @(negedge i_wclk); i_href = 1'b1; i_data = 8'hA5; i_sready = nxt; nxt = 1'b1;
      end
      @(negedge i_wclk); i_href = 1'b0; i_sready = nxt;
      repeat (3) begin @(negedge i_wclk); i_sready = 1'b1; end
    end
    @(negedge i_wclk); i_vsync = 1'b1;
    repeat (5) @(negedge i_wclk);
  endtask

  // Reference: walk lines/pixels applying the capture rules directly.
  task automatic model();
    int y;
    exp_q.delete(); exp_done = 0; exp_le = 0; exp_ovf = 0;
    if (en_a) begin
      y = 0;
      for (int l = 0; l < nl_a; l++) begin
        if (y == V) break;
        for (int p = 0; p < len_a[l]; p++) begin
          if (p < H) begin
            if (rdy_a[l][p]) exp_q.push_back({16'd0, pix_a[l][p], (y == 0 && p == 0), (p == H - 1)});
            else exp_ovf = 1;
          end else exp_le = 1;
        end
        if (len_a[l] != H) exp_le = 1;
        y++;
        if (y == V) exp_done = 1;
      end
      if (y < V) exp_le = 1;
    end
  endtask

  task automatic run_frame(input string name);
    got_q.delete(); done_cnt = 0;
    drive_frame();
    model();
    exp_cnt = exp_cnt + 16'(exp_done);
    check({name, "_beats"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({name, "_beat_data"}, 64'(got_q[i]), 64'(exp_q[i]));
    check({name, "_done"}, 64'(done_cnt), 64'(exp_done));
    check({name, "_frame_cnt"}, 64'(o_frame_cnt), 64'(exp_cnt));
    check({name, "_overflow"}, 64'(o_overflow), 64'(exp_ovf));
    check({name, "_line_err"}, 64'(o_line_err), 64'(exp_le));
  endtask

  task automatic clear_errs(input string name);
    @(negedge i_wclk); i_clr_err = 1'b1;
    @(negedge i_wclk); i_clr_err = 1'b0;
    @(negedge i_wclk);
    check({name, "_ovf_cleared"}, 64'(o_overflow), 64'd0);
    check({name, "_le_cleared"}, 64'(o_line_err), 64'd0);
  endtask

  typedef struct {
    bit en; int nl; int len0; int len1; int drop; bit odd;
    int beats; int done; bit le; bit ovf;
  } vec_t;
  vec_t tbl[7];

  initial begin
    tbl[0] = '{1, 2, 4, 4, -1, 0, 8, 1, 0, 0}; // nominal
    tbl[1] = '{1, 2, 4, 4,  2, 0, 7, 1, 0, 1}; // 3rd pixel refused
    tbl[2] = '{1, 2, 5, 4, -1, 0, 8, 1, 1, 0}; // long line
    tbl[3] = '{1, 2, 3, 4, -1, 0, 7, 1, 1, 0}; // short line
    tbl[4] = '{0, 2, 4, 4, -1, 0, 0, 0, 0, 0}; // disabled
    tbl[5] = '{1, 1, 4, 0, -1, 0, 4, 0, 1, 0}; // aborted by VSYNC
    tbl[6] = '{1, 2, 4, 4, -1, 1, 8, 1, 0, 0}; // dangling odd byte

    i_rrstn = 1'b0; i_vsync = 1'b1; i_href = 1'b0; i_data = 8'h00;
    i_en = 1'b0; i_clr_err = 1'b0; i_sready = 1'b1;
    repeat (3) @(negedge i_wclk);
    check("rst_valid", 64'(o_wr_valid), 64'd0);
    check("rst_data", 64'(o_wr_data), 64'd0);
    check("rst_done", 64'(o_frame_done), 64'd0);
    check("rst_cnt", 64'(o_frame_cnt), 64'd0);
    check("rst_ovf", 64'(o_overflow), 64'd0);
    check("rst_le", 64'(o_line_err), 64'd0);
    i_rrstn = 1'b1;
    repeat (4) @(negedge i_wclk);

    for (int t = 0; t < 7; t++) begin
      setup_frame(tbl[t].en, tbl[t].nl, tbl[t].len0, tbl[t].len1, 0, tbl[t].odd, tbl[t].drop, 1'b0);
      run_frame($sformatf("vec%0d", t));
      check($sformatf("vec%0d_tbl_beats", t), 64'(got_q.size()), 64'(tbl[t].beats));
      check($sformatf("vec%0d_tbl_done", t), 64'(done_cnt), 64'(tbl[t].done));
      check($sformatf("vec%0d_tbl_le", t), 64'(o_line_err), 64'(tbl[t].le));
      check($sformatf("vec%0d_tbl_ovf", t), 64'(o_overflow), 64'(tbl[t].ovf));
      if (t == 0) begin
        check("vec0_first_beat", 64'(got_q.size() > 0 ? got_q[0] : 34'd0),
              64'({32'h0000_1234, 1'b1, 1'b0}));
        check("vec0_beat4_tlast", 64'(got_q.size() > 3 ? got_q[3][0] : 1'b0), 64'd1);
        check("vec0_beat8_tlast", 64'(got_q.size() > 7 ? got_q[7][0] : 1'b0), 64'd1);
      end
      clear_errs($sformatf("vec%0d", t));
    end

    // Reset pulsed in the middle of a line
    @(negedge i_wclk); i_en = 1'b1; i_vsync = 1'b0;
    repeat (4) @(negedge i_wclk);
    for (int k = 0; k < 3; k++) begin @(negedge i_wclk); i_href = 1'b1; i_data = 8'(k + 1); end
    @(negedge i_wclk); i_rrstn = 1'b0;
    #1;
    check("midrst_valid", 64'(o_wr_valid), 64'd0);
    check("midrst_data", 64'(o_wr_data), 64'd0);
    check("midrst_done", 64'(o_frame_done), 64'd0);
    check("midrst_cnt", 64'(o_frame_cnt), 64'd0);
    check("midrst_ovf", 64'(o_overflow), 64'd0);
    check("midrst_le", 64'(o_line_err), 64'd0);
    @(negedge i_wclk);
    @(negedge i_wclk); i_rrstn = 1'b1;
    got_q.delete(); done_cnt = 0; exp_cnt = 16'd0;
    for (int k = 0; k < 5; k++) begin @(negedge i_wclk); i_href = 1'b1; i_data = 8'(k + 8'h40); end
    @(negedge i_wclk); i_href = 1'b0;
    repeat (3) @(negedge i_wclk);
    for (int k = 0; k < 8; k++) begin @(negedge i_wclk); i_href = 1'b1; i_data = 8'(k + 8'h60); end
    @(negedge i_wclk); i_href = 1'b0;
    repeat (3) @(negedge i_wclk);
    check("postrst_no_beats", 64'(got_q.size()), 64'd0);
    check("postrst_no_done", 64'(done_cnt), 64'd0);
    check("postrst_le", 64'(o_line_err), 64'd0);
    @(negedge i_wclk); i_vsync = 1'b1;
    repeat (5) @(negedge i_wclk);

    for (int r = 0; r < 10; r++) begin
      setup_frame(($urandom_range(0, 4) != 0), int'($urandom_range(1, 3)),
                  int'($urandom_range(2, 5)), int'($urandom_range(2, 5)), int'($urandom_range(2, 5)),
                  bit'($urandom_range(0, 1)), -1, 1'b1);
      run_frame($sformatf("rnd%0d", r));
      clear_errs($sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
